// File: rtl/rom_boot_loader_pkg.sv
// Shared types and widths for the instruction-ROM boot loader: frame field widths
// and loader state encodings.
package rom_boot_loader_pkg;

    localparam int unsigned COUNT_WIDTH      = 16;
    localparam int unsigned COUNT_EXT_WIDTH  = COUNT_WIDTH + 1;
    localparam int unsigned BYTE_WIDTH       = 8;
    localparam int unsigned WORD_WIDTH       = 32;
    localparam int unsigned BYTES_PER_WORD   = WORD_WIDTH / BYTE_WIDTH;
    localparam int unsigned BYTE_INDEX_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_HEADER_HIGH = 3'd0,
        ST_HEADER_LOW  = 3'd1,
        ST_DATA        = 3'd2,
        ST_CHECK       = 3'd3,
        ST_DONE        = 3'd4,
        ST_ERROR       = 3'd5
    } loader_state_e;

    // Stream bytes are only taken while the frame is still being parsed.
    function automatic logic accepts_bytes(input loader_state_e state);
        return (state == ST_HEADER_HIGH) || (state == ST_HEADER_LOW) ||
               (state == ST_DATA)        || (state == ST_CHECK);
    endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Byte-stream input, ROM write port and CPU control bundle of the boot loader.
interface rom_boot_loader_if
    import rom_boot_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10
);
    logic                     in_valid;
    logic [BYTE_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     rom_write_enable;
    logic [ADDRESS_WIDTH-1:0] rom_write_address;
    logic [WORD_WIDTH-1:0]    rom_write_data;
    logic                     cpu_reset;
    logic                     done;
    logic                     error;

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_write_enable, rom_write_address, rom_write_data,
               cpu_reset, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_write_enable, rom_write_address, rom_write_data,
               cpu_reset, done, error
    );
endinterface

// File: rtl/rom_boot_loader_byte_word_packer.sv
// Assembles big-endian 32-bit words from accepted bytes; flags the fourth byte of each word.
module rom_boot_loader_byte_word_packer
    import rom_boot_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  word_ready_c,
    output logic [WORD_WIDTH-1:0] word_c
);
    localparam int unsigned SHIFT_WIDTH = WORD_WIDTH - BYTE_WIDTH;
    localparam logic [BYTE_INDEX_WIDTH-1:0] LAST_INDEX = BYTE_INDEX_WIDTH'(BYTES_PER_WORD - 1);

    logic [SHIFT_WIDTH-1:0]      shift_q, shift_d;
    logic [BYTE_INDEX_WIDTH-1:0] byte_idx_q, byte_idx_d;

    always_comb begin
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        if (byte_valid) begin
            shift_d    = {shift_q[SHIFT_WIDTH-BYTE_WIDTH-1:0], byte_data};
            byte_idx_d = byte_idx_q + BYTE_INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // The word is complete combinationally with the incoming fourth byte.
    assign word_ready_c = byte_valid && (byte_idx_q == LAST_INDEX);
    assign word_c       = {shift_q, byte_data};

endmodule

// File: rtl/rom_boot_loader.sv
// Boot loader: parses COUNT/payload/CHECK frames, writes instruction words into ROM from
// word 0 and releases CPU reset only once the whole image checksum matches.
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10
)(
    input  logic              clock,
    input  logic              reset,
    rom_boot_loader_if.slave  bus
);
    localparam int unsigned WORD_COUNT_WIDTH = ADDRESS_WIDTH + 1;
    localparam int unsigned COUNT_HI_WIDTH   = COUNT_WIDTH - BYTE_WIDTH;
    localparam logic [COUNT_EXT_WIDTH-1:0] DEPTH = COUNT_EXT_WIDTH'(1) << ADDRESS_WIDTH;

    loader_state_e               state_q, state_d;
    logic [COUNT_HI_WIDTH-1:0]   count_hi_q, count_hi_d;
    logic [COUNT_WIDTH-1:0]      count_q, count_d;
    logic [WORD_COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [BYTE_WIDTH-1:0]       checksum_q, checksum_d;
    logic                        we_q, we_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [WORD_WIDTH-1:0]       data_q, data_d;
    logic                        cpu_reset_q, cpu_reset_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic                        in_ready_c;
    logic                        transfer_c;
    logic                        word_ready_c;
    logic [WORD_WIDTH-1:0]       word_c;
    logic [COUNT_WIDTH-1:0]      header_count_c;
    logic                        last_word_c;

    assign in_ready_c     = !reset && accepts_bytes(state_q);
    assign transfer_c     = bus.in_valid && in_ready_c;
    assign header_count_c = {count_hi_q, bus.in_data};
    assign last_word_c    = (COUNT_WIDTH'(word_cnt_q) == (count_q - COUNT_WIDTH'(1)));

    rom_boot_loader_byte_word_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .byte_valid   (transfer_c && (state_q == ST_DATA)),
        .byte_data    (bus.in_data),
        .word_ready_c (word_ready_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_HEADER_HIGH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HEADER_HIGH: if (transfer_c) state_d = ST_HEADER_LOW;
            ST_HEADER_LOW: begin
                if (transfer_c) begin
                    if ((header_count_c == '0) || ({1'b0, header_count_c} > DEPTH))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA:  if (word_ready_c && last_word_c) state_d = ST_CHECK;
            ST_CHECK: begin
                if (transfer_c)
                    state_d = (bus.in_data == checksum_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = state_q;
        endcase
    end

    // Datapath and registered outputs; status flags follow the state being entered.
    always_comb begin
        count_hi_d  = count_hi_q;
        count_d     = count_q;
        word_cnt_d  = word_cnt_q;
        checksum_d  = checksum_q;
        we_d        = word_ready_c;
        addr_d      = addr_q;
        data_d      = data_q;
        if (transfer_c && (state_q == ST_HEADER_HIGH)) count_hi_d = bus.in_data;
        if (transfer_c && (state_q == ST_HEADER_LOW))  count_d    = header_count_c;
        if (transfer_c && (state_q == ST_DATA))        checksum_d = checksum_q ^ bus.in_data;
        if (word_ready_c) begin
            addr_d     = word_cnt_q[ADDRESS_WIDTH-1:0];
            data_d     = word_c;
            word_cnt_d = word_cnt_q + WORD_COUNT_WIDTH'(1);
        end
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_hi_q  <= '0;
            count_q     <= '0;
            word_cnt_q  <= '0;
            checksum_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            count_hi_q  <= count_hi_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            checksum_q  <= checksum_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready          = in_ready_c;
    assign bus.rom_write_enable  = we_q;
    assign bus.rom_write_address = addr_q;
    assign bus.rom_write_data    = data_q;
    assign bus.cpu_reset         = cpu_reset_q;
    assign bus.done              = done_q;
    assign bus.error             = error_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: table of frame scenarios plus a mid-frame reset sequence.
module tb_rom_boot_loader;
    import rom_boot_loader_pkg::*;

    localparam int unsigned AW = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rom_boot_loader_if #(.ADDRESS_WIDTH(AW)) bus ();

    rom_boot_loader #(.ADDRESS_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    logic [AW-1:0] seen_addr[$];
    logic [31:0]   seen_data[$];
    int            seen_cyc[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int            exp_cyc[$];
    logic          prev_we = 1'b0;

    // ROM write monitor; a strobe is legal only if the previous cycle had none.
    always @(negedge clock) begin
        if (bus.rom_write_enable === 1'b1) begin
            seen_addr.push_back(bus.rom_write_address);
            seen_data.push_back(bus.rom_write_data);
            seen_cyc.push_back(cyc);
            check("strobe_single_cycle", 64'(prev_we), 64'd0);
        end
        prev_we = (bus.rom_write_enable === 1'b1);
    end

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return 32'h3C02_0404;
            1:       return 32'h3442_0404;
            default: return (32'(i) * 32'h0100_0193) ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic clear_writes();
        seen_addr.delete(); seen_data.delete(); seen_cyc.delete();
        exp_addr.delete();  exp_data.delete();  exp_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},        64'(bus.rom_write_enable),  64'd0);
        check({tag, "_addr"},      64'(bus.rom_write_address), 64'd0);
        check({tag, "_data"},      64'(bus.rom_write_data),    64'd0);
        check({tag, "_cpu_reset"}, 64'(bus.cpu_reset),         64'd1);
        check({tag, "_done"},      64'(bus.done),              64'd0);
        check({tag, "_error"},     64'(bus.error),             64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),          64'd1);
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic apply_reset(input string tag);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_ready_during_reset"}, 64'(bus.in_ready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        clear_writes();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int xcyc);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            xcyc = -1;
            return;
        end
        @(posedge clock); #1;
        xcyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] count, input int nwords, input logic corrupt,
                              input int gap_max);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  b;
        int          x;
        sum = 8'h00;
        send_byte(count[15:8], $urandom_range(0, gap_max), x);
        if (nwords == 0) begin
            check("error_before_header_low", 64'(bus.error), 64'd0);
            send_byte(count[7:0], $urandom_range(0, gap_max), x);
            return;
        end
        send_byte(count[7:0], $urandom_range(0, gap_max), x);
        for (int i = 0; i < nwords; i++) begin
            w = word_of(i);
            for (int k = 0; k < 4; k++) begin
                b = w[31 - 8*k -: 8];
                sum ^= b;
                send_byte(b, $urandom_range(0, gap_max), x);
                if (k == 3) begin
                    exp_addr.push_back(AW'(i));
                    exp_data.push_back(w);
                    exp_cyc.push_back(x);
                end
            end
        end
        check("done_before_check", 64'(bus.done), 64'd0);
        check("error_before_check", 64'(bus.error), 64'd0);
        send_byte(corrupt ? ~sum : sum, $urandom_range(0, gap_max), x);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_write_count"}, 64'(seen_addr.size()), 64'(exp_addr.size()));
        n = (seen_addr.size() < exp_addr.size()) ? seen_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_write_addr"},    64'(seen_addr[i]), 64'(exp_addr[i]));
            check({tag, "_write_data"},    64'(seen_data[i]), 64'(exp_data[i]));
            check({tag, "_write_latency"}, 64'(seen_cyc[i]),  64'(exp_cyc[i]));
        end
    endtask

    task automatic offer_extra(input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_extra_not_ready"}, 64'(bus.in_ready), 64'd0);
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    typedef struct {
        string       name;
        logic [15:0] count;
        int          nwords;
        logic        corrupt;
        int          gap_max;
        logic        exp_done;
        logic        exp_error;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int x;
        vecs[0] = '{"good2",      16'h0002, 2,    1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{"badcheck",   16'h0002, 2,    1'b1, 0, 1'b0, 1'b1};
        vecs[2] = '{"count0",     16'h0000, 0,    1'b0, 0, 1'b0, 1'b1};
        vecs[3] = '{"count401",   16'h0401, 0,    1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{"count400",   16'h0400, 1024, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{"gaps",       16'h0002, 2,    1'b0, 3, 1'b1, 1'b0};
        vecs[6] = '{"good1",      16'h0001, 1,    1'b0, 1, 1'b1, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clock); #1;

        foreach (vecs[v]) begin
            apply_reset({vecs[v].name, "_rst"});
            send_frame(vecs[v].count, vecs[v].nwords, vecs[v].corrupt, vecs[v].gap_max);
            check({vecs[v].name, "_done"},      64'(bus.done),      64'(vecs[v].exp_done));
            check({vecs[v].name, "_error"},     64'(bus.error),     64'(vecs[v].exp_error));
            check({vecs[v].name, "_cpu_reset"}, 64'(bus.cpu_reset), 64'(!vecs[v].exp_done));
            check({vecs[v].name, "_in_ready"},  64'(bus.in_ready),  64'd0);
            offer_extra(vecs[v].name);
            compare_writes(vecs[v].name);
            if (vecs[v].nwords > 0)
                check({vecs[v].name, "_last_addr"}, 64'(seen_addr.size() > 0 ? seen_addr[$] : '1),
                      64'(vecs[v].nwords - 1));
        end

        // Reset one cycle after the sixth payload byte: word 1 must never be written.
        apply_reset("midrst_pre");
        send_byte(8'h00, 0, x);
        send_byte(8'h02, 0, x);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] w;
            w = word_of(k / 4);
            send_byte(w[31 - 8*(k % 4) -: 8], 0, x);
            if (k == 3) begin
                exp_addr.push_back(AW'(0));
                exp_data.push_back(w);
                exp_cyc.push_back(x);
            end
        end
        reset = 1'b1;
        #1;
        check("midrst_ready_during_reset", 64'(bus.in_ready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst_post");
        repeat (6) @(posedge clock);
        #1;
        compare_writes("midrst_partial");
        clear_writes();
        send_frame(16'h0002, 2, 1'b0, 0);
        check("midrst_done",      64'(bus.done),      64'd1);
        check("midrst_error",     64'(bus.error),     64'd0);
        check("midrst_cpu_reset", 64'(bus.cpu_reset), 64'd0);
        offer_extra("midrst");
        compare_writes("midrst_full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
